// File: rtl/score4_move_sequencer_if.sv
// score4_move_sequencer_if: controls/checker verdict in (left,right,put,frame_tick,win_det), game state out (player,cursor_col,panel_a/b,invalid_move,win_a/b,full_panel,busy)
interface score4_move_sequencer_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int CW   = 3
);
  logic                   left;
  logic                   right;
  logic                   put;
  logic                   frame_tick;
  logic [1:0]             win_det;
  logic                   player;
  logic [CW-1:0]          cursor_col;
  logic [ROWS*COLS-1:0]   panel_a;
  logic [ROWS*COLS-1:0]   panel_b;
  logic                   invalid_move;
  logic                   win_a;
  logic                   win_b;
  logic                   full_panel;
  logic                   busy;
  modport master (
    output left, right, put, frame_tick, win_det,
    input  player, cursor_col, panel_a, panel_b, invalid_move, win_a, win_b, full_panel, busy
  );
  modport slave (
    input  left, right, put, frame_tick, win_det,
    output player, cursor_col, panel_a, panel_b, invalid_move, win_a, win_b, full_panel, busy
  );
endinterface

// File: rtl/score4_move_sequencer.sv
// score4_move_sequencer: frame-synchronous move/turn controller; clk, rst, bus (slave: controls + win_det in, cursor/player/panels/flags/busy out)
module score4_move_sequencer #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int CW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  score4_move_sequencer_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int IW = $clog2(N);
  localparam int NW = $clog2(N + 1);
  localparam logic [1:0] C_LEFT  = 2'd0;
  localparam logic [1:0] C_RIGHT = 2'd1;
  localparam logic [1:0] C_PUT   = 2'd2;
  typedef enum logic [2:0] {IDLE, EXEC, SCAN, WRITE, CHECK, OVER} state_t;
  state_t          state_q, state_d;
  logic            l_q, r_q, p_q;
  logic            pend_q, pend_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   cur_q, cur_d;
  logic            player_q, player_d;
  logic [N-1:0]    pa_q, pa_d, pb_q, pb_d;
  logic            inv_q, inv_d, wa_q, wa_d, wb_q, wb_d, full_q, full_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            lr, rr, pr, take, occ, done, at_max, at_min;
  logic [IW-1:0]   idx;
  assign lr     = bus.left  & ~l_q;
  assign rr     = bus.right & ~r_q;
  assign pr     = bus.put   & ~p_q;
  assign take   = ~pend_q & ((state_q == IDLE) | (state_q == OVER)) & (lr | rr | pr);
  assign idx    = IW'(row_q) * IW'(COLS) + IW'(cur_q);
  assign occ    = pa_q[idx] | pb_q[idx];
  assign done   = bus.win_det[0] | bus.win_det[1] | (cnt_q == NW'(N));
  assign at_max = cur_q == CW'(COLS - 1);
  assign at_min = cur_q == '0;
  always_comb begin
    state_d  = state_q;
    pend_d   = take ? 1'b1 : pend_q;
    cmd_d    = take ? (pr ? C_PUT : rr ? C_RIGHT : C_LEFT) : cmd_q;
    row_d    = row_q;
    cur_d    = cur_q;
    player_d = player_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    inv_d    = inv_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    full_d   = full_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: if (bus.frame_tick && pend_q) begin
        pend_d  = 1'b0;
        state_d = EXEC;
      end
      EXEC: begin
        row_d   = '0;
        state_d = (cmd_q == C_PUT) ? SCAN : IDLE;
        if (cmd_q == C_RIGHT) begin
          inv_d = at_max;
          cur_d = at_max ? cur_q : cur_q + 1'b1;
        end else if (cmd_q == C_LEFT) begin
          inv_d = at_min;
          cur_d = at_min ? cur_q : cur_q - 1'b1;
        end
      end
      SCAN: if (!occ) begin
        pa_d[idx] = pa_q[idx] | ~player_q;
        pb_d[idx] = pb_q[idx] | player_q;
        state_d   = WRITE;
      end else if (row_q == RW'(ROWS - 1)) begin
        inv_d   = 1'b1;
        state_d = IDLE;
      end else begin
        row_d = row_q + 1'b1;
      end
      WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        inv_d   = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        wa_d     = wa_q | bus.win_det[0];
        wb_d     = wb_q | bus.win_det[1];
        full_d   = full_q | (cnt_q == NW'(N));
        player_d = done ? player_q : ~player_q;
        state_d  = done ? OVER : IDLE;
      end
      OVER: if (bus.frame_tick) pend_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      l_q      <= 1'b0;
      r_q      <= 1'b0;
      p_q      <= 1'b0;
      pend_q   <= 1'b0;
      cmd_q    <= C_LEFT;
      row_q    <= '0;
      cur_q    <= '0;
      player_q <= 1'b0;
      pa_q     <= '0;
      pb_q     <= '0;
      inv_q    <= 1'b0;
      wa_q     <= 1'b0;
      wb_q     <= 1'b0;
      full_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      l_q      <= bus.left;
      r_q      <= bus.right;
      p_q      <= bus.put;
      pend_q   <= pend_d;
      cmd_q    <= cmd_d;
      row_q    <= row_d;
      cur_q    <= cur_d;
      player_q <= player_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      inv_q    <= inv_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      full_q   <= full_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.player       = player_q;
  assign bus.cursor_col   = cur_q;
  assign bus.panel_a      = pa_q;
  assign bus.panel_b      = pb_q;
  assign bus.invalid_move = inv_q;
  assign bus.win_a        = wa_q;
  assign bus.win_b        = wb_q;
  assign bus.full_panel   = full_q;
  assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_score4_move_sequencer.sv
// tb_score4_move_sequencer: scoreboard bench with stub win checker and directed game scenarios
module tb_score4_move_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_req = 1'b0;
  logic stub_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  always #10 clk = ~clk;
  score4_move_sequencer_if #(.COLS(7), .ROWS(6), .CW(3)) bus ();
  score4_move_sequencer #(.COLS(7), .ROWS(6), .CW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.win_det = {1'b0, stub_en & bus.panel_a[0] & bus.panel_a[7] & bus.panel_a[14] & bus.panel_a[21]};
  typedef struct packed {
    logic        player;
    logic [2:0]  cur;
    logic [41:0] a;
    logic [41:0] b;
    logic        inv;
    logic        wa;
    logic        wb;
    logic        full;
    logic        busy;
  } snap_t;
  snap_t expq[$];
  string nameq[$];
  snap_t m;
  int    m_cnt;
  logic  busy_p = 1'b0;
  logic  fl_p = 1'b0;
  always @(negedge clk) begin
    automatic logic fl = bus.win_a | bus.win_b | bus.full_panel;
    automatic snap_t got = {bus.player, bus.cursor_col, bus.panel_a, bus.panel_b,
                            bus.invalid_move, bus.win_a, bus.win_b, bus.full_panel, bus.busy};
    automatic snap_t e;
    automatic string n;
    if (!rst && ((busy_p && !bus.busy) || (!fl_p && fl) || chk_req)) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: DUT produced an outcome with nothing expected (busy=%0d flags=%0d)", bus.busy, fl);
      end else begin
        e = expq.pop_front();
        n = nameq.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL %s: got p=%0d col=%0d a=%h b=%h inv=%0d wa=%0d wb=%0d full=%0d busy=%0d; want p=%0d col=%0d a=%h b=%h inv=%0d wa=%0d wb=%0d full=%0d busy=%0d",
                   n, got.player, got.cur, got.a, got.b, got.inv, got.wa, got.wb, got.full, got.busy,
                   e.player, e.cur, e.a, e.b, e.inv, e.wa, e.wb, e.full, e.busy);
        end
      end
    end
    busy_p = bus.busy;
    fl_p   = fl;
  end
  task automatic push(input snap_t s, input string n);
    expq.push_back(s);
    nameq.push_back(n);
  endtask
  task automatic chk(input string n);
    push(m, n);
    @(posedge clk); #1 chk_req = 1'b1;
    @(posedge clk); #1 chk_req = 1'b0;
  endtask
  task automatic apply(input bit l, input bit r, input bit p);
    int land;
    if (m.busy) return;
    if (p) begin
      land = -1;
      for (int i = 5; i >= 0; i--) if (!(m.a[i*7+int'(m.cur)] | m.b[i*7+int'(m.cur)])) land = i;
      if (land < 0) m.inv = 1'b1;
      else begin
        if (m.player) m.b[land*7+int'(m.cur)] = 1'b1;
        else          m.a[land*7+int'(m.cur)] = 1'b1;
        m_cnt++;
        m.inv  = 1'b0;
        m.wa   = m.wa | (stub_en & m.a[0] & m.a[7] & m.a[14] & m.a[21]);
        m.full = m_cnt == 42;
        if (m.wa || m.full) m.busy = 1'b1;
        else m.player = ~m.player;
      end
    end else if (r) begin
      m.inv = m.cur == 3'd6;
      if (!m.inv) m.cur++;
    end else if (l) begin
      m.inv = m.cur == 3'd0;
      if (!m.inv) m.cur--;
    end
  endtask
  task automatic press(input bit l, input bit r, input bit p);
    @(posedge clk); #1 bus.left = l; bus.right = r; bus.put = p;
    @(posedge clk); #1 bus.left = 1'b0; bus.right = 1'b0; bus.put = 1'b0;
  endtask
  task automatic frame();
    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    repeat (12) @(posedge clk);
  endtask
  task automatic tick_exec(input bit l, input bit r, input bit p, input string n);
    bit was_over = m.busy;
    apply(l, r, p);
    if (!was_over) push(m, n);
    frame();
    if (was_over) chk(n);
  endtask
  task automatic cmd(input bit l, input bit r, input bit p, input string n);
    press(l, r, p);
    tick_exec(l, r, p, n);
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m = '0;
    m_cnt = 0;
    chk("reset_state");
  endtask
  initial begin
    snap_t h;
    bus.left = 1'b0; bus.right = 1'b0; bus.put = 1'b0; bus.frame_tick = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) frame();
    chk("idle_frames");
    cmd(1, 0, 0, "left_at_col0");
    for (int i = 0; i < 8; i++) cmd(0, 1, 0, "right_sweep");
    cmd(0, 0, 1, "legal_put_clears_invalid");
    do_reset();
    for (int i = 0; i < 7; i++) cmd(0, 0, 1, "col0_stack");
    h = '0;
    h.a = 42'h0_1000_4001;
    h.b = 42'h8_0020_0080;
    h.inv = 1'b1;
    push(h, "col0_stack_hand");
    @(posedge clk); #1 chk_req = 1'b1;
    @(posedge clk); #1 chk_req = 1'b0;
    do_reset();
    stub_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 1, "win_a_put");
      if (i < 3) begin
        cmd(0, 1, 0, "win_right");
        cmd(0, 0, 1, "win_b_put");
        cmd(1, 0, 0, "win_left");
      end
    end
    cmd(0, 0, 1, "over_put_ignored");
    cmd(0, 1, 0, "over_right_ignored");
    stub_en = 1'b0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < 6; k++) cmd(0, 0, 1, "fill_put");
      if (c < 6) cmd(0, 1, 0, "fill_right");
    end
    cmd(0, 0, 1, "full_put_ignored");
    do_reset();
    cmd(0, 1, 0, "pre_right");
    cmd(1, 0, 1, "put_beats_left");
    press(0, 1, 0);
    repeat (5) @(posedge clk);
    chk("no_tick_no_change");
    tick_exec(0, 1, 0, "deferred_right");
    for (int i = 0; i < 3; i++) cmd(0, 0, 1, "col2_stack");
    press(0, 0, 1);
    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    @(posedge clk);
    do_reset();
    repeat (20) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected outcomes never observed, want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
